io_bridge: RTL



---
 rtl/io_bridge.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/io_bridge.sv
// io_bridge: posts console writes through a small FIFO and serialises blocking reads behind them.
// Define IO_BRIDGE_STATS_EN to add the stat_writes / stat_reads / stat_stall_cycles counters.
module io_bridge #(
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        req_hit,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [7:0]  io_addr,
  output logic        io_read_write,
  output logic        io_enable,
  output logic [31:0] io_data_in,
  input  logic [31:0] io_data_out,
  input  logic        io_exit,
  output logic        halted
`ifdef IO_BRIDGE_STATS_EN
  ,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_stall_cycles
`endif
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, DRAIN, RD_ISSUE, RD_WAIT, RD_RSP, HALT} state_t;

  state_t        state_q, state_d;
  logic [39:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [7:0]    io_addr_q, io_addr_d;
  logic          io_read_write_q, io_read_write_d;
  logic          io_enable_q, io_enable_d;
  logic [31:0]   io_data_in_q, io_data_in_d;
  logic          halted_q, halted_d;

  logic          is_load, is_store, fifo_empty, fifo_full, pop, push;
  logic [39:0]   head_entry;
  logic          unused_addr_bits;

  assign req_hit          = req_valid && (req_addr[31:16] == IO_BASE[31:16]);
  assign is_load          = req_hit && !req_write;
  assign is_store         = req_hit && req_write;
  assign fifo_empty       = (count_q == '0);
  assign fifo_full        = (count_q == FULL_COUNT);
  assign pop              = ((state_q == IDLE) || (state_q == DRAIN)) && !fifo_empty && !io_exit;
  assign head_entry       = fifo_mem[rd_ptr_q];
  assign unused_addr_bits = ^req_addr[15:8];

  // While a read is in flight the held request is the load itself.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:                     stall = is_load || (is_store && fifo_full && !pop);
      DRAIN, RD_ISSUE, RD_WAIT: stall = 1'b1;
      RD_RSP:                   stall = 1'b0;
      HALT:                     stall = req_hit;
      default:                  stall = 1'b0;
    endcase
  end

  assign push = (state_q == IDLE) && is_store && !stall && !io_exit;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = rsp_rdata_q;
    io_addr_d       = io_addr_q;
    io_read_write_d = io_read_write_q;
    io_enable_d     = 1'b0;
    io_data_in_d    = io_data_in_q;
    halted_d        = halted_q;

    if (pop) begin
      rd_ptr_d        = rd_ptr_q + 1'b1;
      io_enable_d     = 1'b1;
      io_read_write_d = 1'b0;
      io_addr_d       = head_entry[39:32];
      io_data_in_d    = head_entry[31:0];
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (is_load) begin
          if (fifo_empty) begin
            state_d         = RD_ISSUE;
            io_enable_d     = 1'b1;
            io_read_write_d = 1'b1;
            io_addr_d       = req_addr[7:0];
          end else begin
            state_d = DRAIN;
          end
        end
      end
      // Wait until the final write strobe has actually left before reading.
      DRAIN: begin
        if (fifo_empty && !io_enable_q) begin
          state_d         = RD_ISSUE;
          io_enable_d     = 1'b1;
          io_read_write_d = 1'b1;
          io_addr_d       = req_addr[7:0];
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        rsp_rdata_d = io_data_out;
        rsp_valid_d = 1'b1;
        state_d     = RD_RSP;
      end
      RD_RSP:  state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (io_exit) begin
      state_d     = HALT;
      halted_d    = 1'b1;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      io_enable_d = 1'b0;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {req_addr[7:0], req_wdata};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      io_addr_q       <= '0;
      io_read_write_q <= 1'b0;
      io_enable_q     <= 1'b0;
      io_data_in_q    <= '0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      io_addr_q       <= io_addr_d;
      io_read_write_q <= io_read_write_d;
      io_enable_q     <= io_enable_d;
      io_data_in_q    <= io_data_in_d;
      halted_q        <= halted_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign io_addr       = io_addr_q;
  assign io_read_write = io_read_write_q;
  assign io_enable     = io_enable_q;
  assign io_data_in    = io_data_in_q;
  assign halted        = halted_q;

`ifdef IO_BRIDGE_STATS_EN
  logic [31:0] stat_writes_q, stat_reads_q, stat_stall_cycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_writes_q       <= '0;
      stat_reads_q        <= '0;
      stat_stall_cycles_q <= '0;
    end else begin
      if (io_enable_q && !io_read_write_q && (stat_writes_q != '1))
        stat_writes_q <= stat_writes_q + 32'd1;
      if (rsp_valid_q && (stat_reads_q != '1))
        stat_reads_q <= stat_reads_q + 32'd1;
      if (stall && (stat_stall_cycles_q != '1))
        stat_stall_cycles_q <= stat_stall_cycles_q + 32'd1;
    end
  end

  assign stat_writes       = stat_writes_q;
  assign stat_reads        = stat_reads_q;
  assign stat_stall_cycles = stat_stall_cycles_q;
`endif

endmodule
